// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage valid/ready register pipeline with bubble collapse, flush and occupancy count.
// Define DFF_PIPE_PARITY_EN to carry an even-parity bit per stage and expose par_err.
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef DFF_PIPE_PARITY_EN
  ,
  output logic                       par_err
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] acc;
    acc = {CW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      acc = acc + CW'(v[i]);
    end
    return acc;
  endfunction

  logic [DEPTH-1:0] valid_r;
  logic [WIDTH-1:0] data_r [DEPTH];
  logic [CW-1:0]    count_r;

  logic [DEPTH:0]   rdy_s;
  logic [DEPTH-1:0] up_valid_s;
  logic [WIDTH-1:0] up_data_s [DEPTH];
  logic [DEPTH-1:0] valid_nxt_s;
  logic [DEPTH-1:0] ld_s;

  // Backward ready chain: a stage can take a beat if it is empty or its successor is moving.
  always_comb begin
    rdy_s[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_s[i] = !valid_r[i] || rdy_s[i+1];
    end
  end

  // Upstream view of each stage: the producer for stage 0, the previous stage otherwise.
  always_comb begin
    up_valid_s[0] = in_valid;
    up_data_s[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_valid_s[i] = valid_r[i-1];
      up_data_s[i]  = data_r[i-1];
    end
  end

  // Next valid vector and data load enables; flush wins and leaves data untouched.
  always_comb begin
    valid_nxt_s = valid_r;
    ld_s        = {DEPTH{1'b0}};
    if (flush) begin
      valid_nxt_s = {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy_s[i]) begin
          valid_nxt_s[i] = up_valid_s[i];
          ld_s[i]        = up_valid_s[i];
        end else begin
          valid_nxt_s[i] = valid_r[i];
          ld_s[i]        = 1'b0;
        end
      end
    end
  end

  // Stage registers; count tracks the popcount of the valid vector it is loaded alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {DEPTH{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= RESET_VAL;
      end
    end else begin
      valid_r <= valid_nxt_s;
      count_r <= popcount(valid_nxt_s);
      for (int i = 0; i < DEPTH; i++) begin
        if (ld_s[i]) begin
          data_r[i] <= up_data_s[i];
        end
      end
    end
  end

`ifdef DFF_PIPE_PARITY_EN
  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic [DEPTH-1:0] par_r;
  logic [DEPTH-1:0] up_par_s;

  // Parity is generated once at the input and then travels with its beat.
  always_comb begin
    up_par_s[0] = even_par(in_data);
    for (int i = 1; i < DEPTH; i++) begin
      up_par_s[i] = par_r[i-1];
    end
  end

  // Parity stage registers share the data load enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_r <= {DEPTH{even_par(RESET_VAL)}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ld_s[i]) begin
          par_r[i] <= up_par_s[i];
        end
      end
    end
  end

  // Error only qualifies a beat that is actually being offered.
  always_comb begin
    if (valid_r[DEPTH-1]) begin
      par_err = (even_par(data_r[DEPTH-1]) != par_r[DEPTH-1]);
    end else begin
      par_err = 1'b0;
    end
  end
`endif

  assign in_ready  = rdy_s[0];
  assign out_valid = valid_r[DEPTH-1];
  assign out_data  = data_r[DEPTH-1];
  assign count     = count_r;

endmodule
